control_sequencer: RTL

Multi-cycle control sequencer for the binary core: owns the program counter and steps each instruction through FETCH, DECODE, EXECUTE, optional MEMORY, and WRITEBACK. It sits directly upstream of `fetch_instruction`. It drives the instruction-memory address (`ins_pointer`) and `fetch_enable`, and issues one-hot stage enables to decode, ALU, data memory and register write-back. It applies branch/halt outcomes and retires one instruction per pass.

---
 rtl/control_sequencer_pkg.sv | 26 ++
 rtl/control_sequencer_program_counter.sv | 44 ++++
 rtl/control_sequencer.sv | 92 +++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared sizes and state encodings for the multi-cycle control sequencer.
// The sequencer and its program counter both import this package.
package control_sequencer_pkg;

    localparam int unsigned WordSize    = 16;
    localparam int unsigned InsAddrSize = 8;

    localparam logic [2:0] StateIdle      = 3'd0;
    localparam logic [2:0] StateFetch     = 3'd1;
    localparam logic [2:0] StateDecode    = 3'd2;
    localparam logic [2:0] StateExecute   = 3'd3;
    localparam logic [2:0] StateMemory    = 3'd4;
    localparam logic [2:0] StateWriteback = 3'd5;
    localparam logic [2:0] StateHalted    = 3'd6;

    typedef enum logic [2:0] {
        StIdle      = StateIdle,
        StFetch     = StateFetch,
        StDecode    = StateDecode,
        StExecute   = StateExecute,
        StMemory    = StateMemory,
        StWriteback = StateWriteback,
        StHalted    = StateHalted
    } seq_state_e;

endpackage

// File: rtl/control_sequencer_program_counter.sv
// Program counter with the branch flag/target latched in EXECUTE.
// On each advance strobe it moves to the latched target or to PC+1.
module program_counter
    import control_sequencer_pkg::*;
#(
    parameter int unsigned INS_ADDR_SIZE = InsAddrSize
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     latch_en_i,
    input  logic                     branch_taken_i,
    input  logic [INS_ADDR_SIZE-1:0] branch_target_i,
    input  logic                     advance_i,
    output logic [INS_ADDR_SIZE-1:0] pc_o
);

    logic [INS_ADDR_SIZE-1:0] pc_q, pc_d;
    logic                     br_taken_q;
    logic [INS_ADDR_SIZE-1:0] br_target_q;

    always_comb begin
        pc_d = pc_q;
        if (advance_i) begin
            pc_d = br_taken_q ? br_target_q : pc_q + {{(INS_ADDR_SIZE-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q        <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (latch_en_i) begin
                br_taken_q  <= branch_taken_i;
                br_target_q <= branch_target_i;
            end
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle sequencer: steps each instruction FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK,
// issues one-hot stage enables, and counts retired instructions.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned WORD_SIZE     = WordSize,
    parameter int unsigned INS_ADDR_SIZE = InsAddrSize
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     halt,
    input  logic                     mem_access,
    input  logic                     branch_taken,
    input  logic [INS_ADDR_SIZE-1:0] branch_target,
    input  logic                     memory_ready,
    output logic [INS_ADDR_SIZE-1:0] ins_pointer,
    output logic                     fetch_enable,
    output logic                     decode_enable,
    output logic                     execute_enable,
    output logic                     memory_enable,
    output logic                     writeback_enable,
    output logic                     halted,
    output logic [WORD_SIZE-1:0]     retired_count
);

    seq_state_e           state_q, state_d;
    logic [WORD_SIZE-1:0] retired_q, retired_d;
    logic                 retire;

    always_comb begin
        state_d          = state_q;
        fetch_enable     = 1'b0;
        decode_enable    = 1'b0;
        execute_enable   = 1'b0;
        memory_enable    = 1'b0;
        writeback_enable = 1'b0;
        halted           = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                fetch_enable = 1'b1;
                state_d      = StDecode;
            end
            StDecode: begin
                decode_enable = 1'b1;
                state_d       = halt ? StHalted : StExecute;
            end
            StExecute: begin
                execute_enable = 1'b1;
                state_d        = mem_access ? StMemory : StWriteback;
            end
            StMemory: begin
                memory_enable = 1'b1;
                if (memory_ready) state_d = StWriteback;
            end
            StWriteback: begin
                writeback_enable = 1'b1;
                state_d          = StFetch;
            end
            StHalted: halted = 1'b1;
            default:  state_d = StIdle;
        endcase
    end

    assign retire    = writeback_enable;
    assign retired_d = retire ? retired_q + {{(WORD_SIZE-1){1'b0}}, 1'b1} : retired_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired_count = retired_q;

    program_counter #(
        .INS_ADDR_SIZE (INS_ADDR_SIZE)
    ) u_program_counter (
        .clock           (clock),
        .reset           (reset),
        .latch_en_i      (execute_enable),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .advance_i       (retire),
        .pc_o            (ins_pointer)
    );

endmodule
